// File: rtl/music_seq_pkg.sv
// rtl/music_seq_pkg.sv - shared types and constants for the music sequencer
// Contents: seq_state_t FSM encoding, REST_NOTE divider value, default
// beat length and volume step.
package music_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2
  } seq_state_t;

  // A divider of zero silences a channel.
  localparam int REST_NOTE = 0;

  // 12.5M cycles per beat at a 50 MHz clock is 240 BPM.
  localparam int DEFAULT_BEAT_DIV = 12_500_000;
  localparam int DEFAULT_VOL_STEP = 'h0800;

endpackage

// File: rtl/music_rom.sv
// rtl/music_rom.sv - synchronous note table ROM, one divider per channel per beat
// Ports:
//   clk   in   system clock
//   song  in   song number
//   beat  in   beat within the song
//   rdata out  NUM_CH dividers, channel 0 in the LSBs, valid 1 cycle after address
module music_rom
  import music_seq_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int DIV_W    = 22,
  parameter int SONG_LEN = 64,
  parameter int NUM_SONG = 4
) (
  input  logic                          clk,
  input  logic [$clog2(NUM_SONG)-1:0]   song,
  input  logic [$clog2(SONG_LEN)-1:0]   beat,
  output logic [NUM_CH*DIV_W-1:0]       rdata
);

  // Table content is generated: each channel plays a rising line whose base
  // pitch depends on channel and song; channels above 0 rest on odd beats.
  function automatic logic [DIV_W-1:0] note_at(
    input int                          ch,
    input logic [$clog2(NUM_SONG)-1:0] s,
    input logic [$clog2(SONG_LEN)-1:0] b
  );
    if (ch != 0 && b[0])
      return DIV_W'(REST_NOTE);
    return DIV_W'(20000 * (ch + 1) + 1000 * int'(s) + 100 * int'(b));
  endfunction

  always_ff @(posedge clk) begin
    for (int ch = 0; ch < NUM_CH; ch++)
      rdata[ch*DIV_W +: DIV_W] <= note_at(ch, song, beat);
  end

endmodule

// File: rtl/music_sequencer.sv
// rtl/music_sequencer.sv - beat-driven song player with volume and progress LEDs
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   song_sel            requested song (level)
//   play_req            play/pause toggle, rising edge acts
//   stop_req            stop, level-sensitive, wins over play_req
//   vol_up, vol_dw      single-cycle volume step pulses
//   note_div            per-channel divider, 0 = silence, channel 0 in the LSBs
//   volume              amplitude word
//   playing, beat_idx   play status and current beat
//   leds                progress bar
// Build option: SEQ_LOOP_EN makes the song repeat instead of stopping at its end.
module music_sequencer
  import music_seq_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int DIV_W    = 22,
  parameter int VOL_W    = 16,
  parameter int NUM_VOL  = 8,
  parameter int VOL_STEP = DEFAULT_VOL_STEP,
  parameter int BEAT_DIV = DEFAULT_BEAT_DIV,
  parameter int SONG_LEN = 64,
  parameter int NUM_SONG = 4,
  parameter int LED_W    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [$clog2(NUM_SONG)-1:0]   song_sel,
  input  logic                          play_req,
  input  logic                          stop_req,
  input  logic                          vol_up,
  input  logic                          vol_dw,
  output logic [NUM_CH*DIV_W-1:0]       note_div,
  output logic [VOL_W-1:0]              volume,
  output logic                          playing,
  output logic [$clog2(SONG_LEN)-1:0]   beat_idx,
  output logic [LED_W-1:0]              leds
);

  localparam int BEAT_W    = $clog2(SONG_LEN);
  localparam int CNT_W     = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
  localparam int LVL_W     = (NUM_VOL > 1) ? $clog2(NUM_VOL) : 1;
  localparam int LED_SHIFT = BEAT_W - $clog2(LED_W);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BEAT_DIV - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(SONG_LEN - 1);
  localparam logic [LVL_W-1:0]  LVL_MAX   = LVL_W'(NUM_VOL - 1);
  localparam logic [LVL_W-1:0]  LVL_RST   = LVL_W'(NUM_VOL / 2);
  localparam logic [VOL_W-1:0]  STEP      = VOL_W'(VOL_STEP);
  localparam logic [VOL_W-1:0]  VOL_RST   = VOL_W'((NUM_VOL / 2) * VOL_STEP);

  seq_state_t                   state;
  logic [CNT_W-1:0]             beat_cnt;
  logic [$clog2(NUM_SONG)-1:0]  song;
  logic                         play_q;
  logic [LVL_W-1:0]             level;
  logic [NUM_CH*DIV_W-1:0]      rom_q;

  logic play_edge;
  logic beat_tick;
  logic song_chg;

  assign play_edge = play_req & ~play_q;
  assign beat_tick = (beat_cnt == CNT_LAST);
  assign song_chg  = (song_sel != song);

  music_rom #(
    .NUM_CH   (NUM_CH),
    .DIV_W    (DIV_W),
    .SONG_LEN (SONG_LEN),
    .NUM_SONG (NUM_SONG)
  ) u_rom (
    .clk   (clk),
    .song  (song),
    .beat  (beat_idx),
    .rdata (rom_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
      beat_idx <= '0;
      song     <= '0;
      play_q   <= 1'b0;
    end else begin
      play_q <= play_req;
      // Tracking song_sel every cycle covers both the idle latch and the
      // "new song while active" latch; the restart side effects are below.
      song   <= song_sel;
      if (stop_req) begin
        state    <= ST_IDLE;
        beat_cnt <= '0;
        beat_idx <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (play_edge) begin
              state    <= ST_PLAY;
              beat_cnt <= '0;
              beat_idx <= '0;
            end
          end
          ST_PLAY: begin
            if (song_chg) begin
              beat_cnt <= '0;
              beat_idx <= '0;
            end else if (play_edge) begin
              state <= ST_PAUSE;
            end else if (beat_tick) begin
              beat_cnt <= '0;
              if (beat_idx == BEAT_LAST) begin
                beat_idx <= '0;
`ifdef SEQ_LOOP_EN
                state    <= ST_PLAY;
`else
                state    <= ST_IDLE;
`endif
              end else begin
                beat_idx <= beat_idx + BEAT_W'(1);
              end
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
          ST_PAUSE: begin
            if (song_chg) begin
              beat_cnt <= '0;
              beat_idx <= '0;
            end else if (play_edge) begin
              state <= ST_PLAY;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      note_div <= '0;
      playing  <= 1'b0;
      level    <= LVL_RST;
      volume   <= VOL_RST;
    end else begin
      note_div <= (state == ST_PLAY) ? rom_q : '0;
      playing  <= (state == ST_PLAY);
      if (vol_up && !vol_dw && level != LVL_MAX)
        level <= level + LVL_W'(1);
      else if (vol_dw && !vol_up && level != '0)
        level <= level - LVL_W'(1);
      volume <= VOL_W'(level) * STEP;
    end
  end

  // Bar length grows with the song position; each LED covers an equal slice.
  always_comb begin
    leds = '0;
    if (state != ST_IDLE) begin
      for (int i = 0; i < LED_W; i++)
        leds[i] = (BEAT_W'(i) <= (beat_idx >> LED_SHIFT));
    end
  end

endmodule

// File: doc/music_sequencer.md
MUSIC_SEQUENCER -- requirements
Module: music_sequencer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  NUM_CH, 2, number of note channels
  DIV_W, 22, note divider width
  VOL_W, 16, volume word width
  NUM_VOL, 8, number of volume levels
  VOL_STEP, 16'h0800, volume increment per level
  BEAT_DIV, 12_500_000, clk cycles per beat
  SONG_LEN, 64, beats per song (power of 2)
  NUM_SONG, 4, songs in ROM (power of 2)
  LED_W, 16, LED count (power of 2, at most SONG_LEN)
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  single system clock
  rst  in  1  synchronous reset, active-high
  song_sel  in  log2(NUM_SONG)  requested song, level
  play_req  in  1  play/pause toggle, level; rising edge detected internally
  stop_req  in  1  stop, level-sensitive
  vol_up  in  1  debounced single-cycle pulse
  vol_dw  in  1  debounced single-cycle pulse
  note_div  out  NUM_CH*DIV_W  per-channel divider; 0 = silence; channel 0 in the LSBs
  volume  out  VOL_W  amplitude word
  playing  out  1  high in PLAY state
  beat_idx  out  log2(SONG_LEN)  current beat
  leds  out  LED_W  progress bar

Function
REQ-003 FSM SHALL have states IDLE, PLAY and PAUSE.
REQ-004 A play_req rising edge SHALL move IDLE->PLAY with beat_idx=0, PLAY->PAUSE, and PAUSE->PLAY, resuming at the held beat and beat counter.
REQ-005 stop_req high SHALL force IDLE next cycle, clear beat_idx and the beat counter, and take priority over a play_req edge in the same cycle.
REQ-006 In PLAY, the beat counter SHALL count 0..BEAT_DIV-1; on reaching BEAT_DIV-1 it SHALL wrap to 0 and beat_idx SHALL increment.
REQ-007 In PAUSE and IDLE, the beat counter and beat_idx SHALL hold.
REQ-008 A song_sel value differing from the latched song in PLAY or PAUSE SHALL latch the new song, set beat_idx=0, clear the beat counter, and keep the current state.
REQ-009 In IDLE, song_sel SHALL be latched every cycle.
REQ-010 End of song (beat tick at beat_idx=SONG_LEN-1) SHALL behave per REQ-020.
REQ-011 The ROM SHALL be read at address {song, beat_idx} with a 1-cycle registered read; note_div SHALL be registered again, appearing 2 cycles after a beat_idx change.
REQ-012 note_div SHALL be all-zero whenever the state registered 1 cycle earlier is not PLAY.
REQ-013 The volume level SHALL range 0..NUM_VOL-1.
REQ-014 vol_up SHALL increment the level, saturating at NUM_VOL-1; vol_dw SHALL decrement it, saturating at 0; vol_up and vol_dw in the same cycle SHALL leave the level unchanged.
REQ-015 volume SHALL equal level*VOL_STEP, truncated to VOL_W, registered 1 cycle after the level; level 0 SHALL give volume 0.
REQ-016 leds SHALL be all-off in IDLE.
REQ-017 In PLAY or PAUSE, leds[i] SHALL be 1 for i <= beat_idx >> (log2(SONG_LEN)-log2(LED_W)), else 0.
REQ-018 playing SHALL equal (state==PLAY), registered.

Reset
REQ-019 With rst high at a clk edge: state=IDLE, beat counter=0, beat_idx=0, song=0, note_div=0, level=NUM_VOL/2, volume=(NUM_VOL/2)*VOL_STEP, playing=0, leds=0, play_req edge register=0. Reset mid-PLAY SHALL take effect on that same edge.

Configuration
REQ-020 Macro SEQ_LOOP_EN:
  - Defined: end of song wraps beat_idx to 0 and stays in PLAY.
  - Undefined: end of song goes to IDLE with beat_idx=0.

Structure
REQ-021 Package music_seq_pkg SHALL hold the state enum, rest-note constant 0, and the default BEAT_DIV/VOL_STEP constants.
REQ-022 Sub-module music_rom (synchronous ROM, parameters NUM_CH, DIV_W, SONG_LEN, NUM_SONG) SHALL hold the note tables; all other logic SHALL stay in music_sequencer.

Verification
Bench parameters: BEAT_DIV=4, SONG_LEN=16, LED_W=4, NUM_VOL=8.
REQ-023 Reset, then play_req edge -> playing=1 within 2 cycles; beat_idx steps 0,1,2 every 4 cycles; note_div equals ROM{0,beat} 2 cycles after each step.
REQ-024 play_req edge at beat 5 -> beat_idx holds 5 and note_div=0; second edge -> resumes at beat 5 with remaining count preserved.
REQ-025 Play to beat 15 and tick -> SEQ_LOOP_EN defined: beat_idx=0, playing=1; undefined: IDLE, leds=0.
REQ-026 From level 4, 5 vol_up pulses -> level 7, volume=16'h3800; 9 vol_dw pulses -> volume=0; vol_up with vol_dw together -> no change.
REQ-027 song_sel 0->2 at beat 9 in PLAY -> beat_idx=0, note_div=ROM{2,0}; stop_req with play_req edge in the same cycle -> IDLE.
REQ-028 At beat_idx=9 -> leds=4'b0111; rst asserted mid-PLAY -> all outputs at reset values next cycle.
